match_ctrl: RTL and testbench
=============================

MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7: score that ends the match; legal range 1..15.
REQ-002 Parameter SERVE_FRAMES, default 60: frames held in SERVE before play resumes; legal range 1..255.
REQ-003 Parameter POINT_FRAMES, default 30: frames held in POINT after a score; legal range 1..255.
REQ-004 Port clk, input, 1: single clock; every register is on its rising edge.
REQ-005 Port reset, input, 1: reset is synchronous and active-high.
REQ-006 Port vga_v_sync, input, 1: active-low vertical sync, synchronous to clk.
REQ-007 Port start_game, input, 1: level switch; a rising edge starts a match.
REQ-008 Port point_left / point_right, input, 1 each: one-cycle pulses from the engine marking a point for that player.
REQ-009 Port engine_step, output, 1: one-cycle pulse that advances the game engine by one frame.
REQ-010 Port ball_reset, output, 1: one-cycle pulse that re-centres the ball.
REQ-011 Port serve_dir, output, 1: serve direction; 0 = toward left, 1 = toward right.
REQ-012 Port score_left / score_right, output, 4 each: current scores.
REQ-013 Port game_running, output, 1: high in SERVE, PLAY and POINT.
REQ-014 Port game_over, output, 1: high in OVER.
REQ-015 Port winner, output, 1: valid in OVER; 0 = left won, 1 = right won.
REQ-016 Port state, output, 3: current state encoding.

Function
REQ-017 frame_tick shall be a one-cycle internal pulse on the cycle after vga_v_sync is sampled falling (1 then 0).
REQ-018 States and encodings shall be IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
REQ-019 IDLE -> SERVE on a start_game rising edge; on that transition: scores cleared to 0, serve_dir=0, ball_reset pulsed.
REQ-020 SERVE: frame counter cleared on entry and incremented per frame_tick; after SERVE_FRAMES ticks -> PLAY; no engine_step in SERVE.
REQ-021 PLAY: engine_step shall assert in the same cycle as each frame_tick (zero latency).
REQ-022 PLAY: point_left alone -> score_left+1, serve_dir=1, -> POINT; point_right alone -> score_right+1, serve_dir=0, -> POINT.
REQ-023 PLAY: point_left and point_right in the same cycle -> draw: no score change, serve_dir toggles, -> POINT.
REQ-024 Point pulses outside PLAY shall be ignored.
REQ-025 POINT: after POINT_FRAMES frame_ticks -> OVER if either score equals WIN_SCORE, otherwise -> SERVE with ball_reset pulsed on the transition.
REQ-026 OVER: winner = (score_right == WIN_SCORE); scores held; a start_game rising edge behaves exactly as in REQ-019.
REQ-027 start_game low in SERVE, PLAY or POINT shall abort the match to IDLE next cycle; scores are held.
REQ-028 Scores shall saturate at 15 and never wrap.
REQ-029 Frame counter width shall be 8 bits; frame_tick while counter equals target shall not wrap the counter.

Reset
REQ-030 During reset: state=IDLE, all pulse outputs 0, scores 0, serve_dir 0, winner 0, counter 0, edge-detect history registers 0.
REQ-031 Reset mid-match shall take effect on the next clk edge and override every transition and pulse in that cycle.
REQ-032 A start_game input held high through reset release shall not start a match; a fresh rising edge is required.

Configuration
REQ-033 Macro MATCH_CTRL_FRAME_STEP_EN defined: adds input ports step_mode and step_btn (1 bit each); when step_mode=1, frame_tick is generated only on a rising edge of step_btn, and vga_v_sync edges are ignored.
REQ-034 Macro MATCH_CTRL_FRAME_STEP_EN undefined: step_mode and step_btn ports are absent and behaviour follows REQ-017 only.

Structure
REQ-035 Shared package pong_pkg shall hold the state encodings, the score width (4), and the WIN_SCORE / SERVE_FRAMES / POINT_FRAMES defaults.
REQ-036 Sub-module edge_detect (rise/fall pulse generator) shall be used for vga_v_sync, start_game and step_btn.

Verification
REQ-037 Reset, then start_game 0->1 -> SERVE, ball_reset pulse, scores 0/0; 60 frames later -> PLAY.
REQ-038 In PLAY, 5 vsync falls -> exactly 5 engine_step pulses, each coincident with its frame_tick.
REQ-039 point_left in PLAY -> score_left=1, serve_dir=1, POINT; 30 frames later -> SERVE with ball_reset.
REQ-040 point_left and point_right in the same cycle -> scores unchanged, serve_dir toggles.
REQ-041 score_right reaches 7 -> OVER after POINT, game_over=1, winner=1; start_game rising edge -> scores 0/0, SERVE.
REQ-042 With FRAME_STEP_EN and step_mode=1: vsync edges produce no engine_step; 3 step_btn presses in PLAY -> 3 engine_step pulses.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller: state encodings,
// score width, frame counter width and the default match parameters.
package pong_pkg;

    localparam int SCORE_W          = 4;
    localparam int CNT_W            = 8;
    localparam int WIN_SCORE_DEF    = 7;
    localparam int SERVE_FRAMES_DEF = 60;
    localparam int POINT_FRAMES_DEF = 30;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // Scores stick at the top value instead of wrapping back to zero.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == {SCORE_W{1'b1}}) ? s : s + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/match_ctrl_edge_detect.sv
// Edge pulse generator (module edge_detect): registers the input twice and
// emits a one-cycle rise or fall pulse, selected by FALL, the cycle after it.
module edge_detect #(
    parameter bit FALL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sig,
    output logic o_pulse
);

    logic       r_cur;
    logic       r_prev;
    logic [1:0] r_vld;

    // r_vld keeps a level held across reset release from looking like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur  <= 1'b0;
            r_prev <= 1'b0;
            r_vld  <= 2'b00;
        end else begin
            r_cur  <= i_sig;
            r_prev <= r_cur;
            r_vld  <= {r_vld[0], 1'b1};
        end
    end

    assign o_pulse = r_vld[1] & (FALL ? (r_prev & ~r_cur) : (r_cur & ~r_prev));

endmodule

// File: rtl/match_ctrl.sv
// Pong match sequencer: IDLE/SERVE/PLAY/POINT/OVER, scoring, frame pacing.
// Optional MATCH_CTRL_FRAME_STEP_EN adds single-step frame advance by button.
module match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int POINT_FRAMES = POINT_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vga_v_sync,
    input  logic               start_game,
    input  logic               point_left,
    input  logic               point_right,
`ifdef MATCH_CTRL_FRAME_STEP_EN
    input  logic               step_mode,
    input  logic               step_btn,
`endif
    output logic               engine_step,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               game_running,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state
);

    localparam logic [CNT_W-1:0]   SERVE_TGT = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   POINT_TGT = CNT_W'(POINT_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_TGT   = SCORE_W'(WIN_SCORE);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SCORE_W-1:0] r_score_l;
    logic [SCORE_W-1:0] r_score_r;
    logic               r_serve_dir;
    logic               r_ball_reset;
    logic               r_winner;

    logic               w_vs_fall;
    logic               w_start_rise;
    logic               w_frame_tick;
    logic [CNT_W-1:0]   w_cnt_inc;

    edge_detect #(.FALL(1'b1)) u_vs_edge (
        .clk     (clk),
        .reset   (reset),
        .i_sig   (vga_v_sync),
        .o_pulse (w_vs_fall)
    );

    edge_detect #(.FALL(1'b0)) u_start_edge (
        .clk     (clk),
        .reset   (reset),
        .i_sig   (start_game),
        .o_pulse (w_start_rise)
    );

`ifdef MATCH_CTRL_FRAME_STEP_EN
    logic w_step_rise;

    edge_detect #(.FALL(1'b0)) u_step_edge (
        .clk     (clk),
        .reset   (reset),
        .i_sig   (step_btn),
        .o_pulse (w_step_rise)
    );

    assign w_frame_tick = step_mode ? w_step_rise : w_vs_fall;
`else
    assign w_frame_tick = w_vs_fall;
`endif

    assign w_cnt_inc = cnt_inc(r_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_score_l    <= '0;
            r_score_r    <= '0;
            r_serve_dir  <= 1'b0;
            r_ball_reset <= 1'b0;
            r_winner     <= 1'b0;
        end else begin
            r_ball_reset <= 1'b0;
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (w_start_rise) begin
                        r_state      <= ST_SERVE;
                        r_cnt        <= '0;
                        r_score_l    <= '0;
                        r_score_r    <= '0;
                        r_serve_dir  <= 1'b0;
                        r_winner     <= 1'b0;
                        r_ball_reset <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (!start_game) begin
                        r_state <= ST_IDLE;
                    end else if (w_frame_tick) begin
                        if (w_cnt_inc == SERVE_TGT) begin
                            r_state <= ST_PLAY;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                ST_PLAY: begin
                    if (!start_game) begin
                        r_state <= ST_IDLE;
                    end else if (point_left || point_right) begin
                        // Simultaneous points count as a draw: nobody scores.
                        r_state <= ST_POINT;
                        r_cnt   <= '0;
                        if (point_left && point_right) begin
                            r_serve_dir <= ~r_serve_dir;
                        end else if (point_left) begin
                            r_score_l   <= score_inc(r_score_l);
                            r_serve_dir <= 1'b1;
                        end else begin
                            r_score_r   <= score_inc(r_score_r);
                            r_serve_dir <= 1'b0;
                        end
                    end
                end
                ST_POINT: begin
                    if (!start_game) begin
                        r_state <= ST_IDLE;
                    end else if (w_frame_tick) begin
                        if (w_cnt_inc == POINT_TGT) begin
                            r_cnt <= '0;
                            if (r_score_l == WIN_TGT || r_score_r == WIN_TGT) begin
                                r_state  <= ST_OVER;
                                r_winner <= (r_score_r == WIN_TGT);
                            end else begin
                                r_state      <= ST_SERVE;
                                r_ball_reset <= 1'b1;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Engine advance is combinational so it lands on the tick cycle itself.
    assign engine_step  = w_frame_tick && (r_state == ST_PLAY);
    assign ball_reset   = r_ball_reset;
    assign serve_dir    = r_serve_dir;
    assign score_left   = r_score_l;
    assign score_right  = r_score_r;
    assign game_running = (r_state == ST_SERVE) || (r_state == ST_PLAY) || (r_state == ST_POINT);
    assign game_over    = (r_state == ST_OVER);
    assign winner       = r_winner;
    assign state        = r_state;

endmodule

// File: tb/tb_match_ctrl.sv
// Directed bench for match_ctrl: expected engine_step events are queued when
// frames are driven in PLAY and checked by a monitor as the DUT pulses.
module tb_match_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       vga_v_sync;
    logic       start_game;
    logic       point_left;
    logic       point_right;
`ifdef MATCH_CTRL_FRAME_STEP_EN
    logic       step_mode;
    logic       step_btn;
`endif
    logic       engine_step;
    logic       ball_reset;
    logic       serve_dir;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_running;
    logic       game_over;
    logic       winner;
    logic [2:0] state;

    int vectors     = 0;
    int miscompares = 0;
    int step_cnt    = 0;
    int br_cnt      = 0;
    int exp_q[$];

    match_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .vga_v_sync   (vga_v_sync),
        .start_game   (start_game),
        .point_left   (point_left),
        .point_right  (point_right),
`ifdef MATCH_CTRL_FRAME_STEP_EN
        .step_mode    (step_mode),
        .step_btn     (step_btn),
`endif
        .engine_step  (engine_step),
        .ball_reset   (ball_reset),
        .serve_dir    (serve_dir),
        .score_left   (score_left),
        .score_right  (score_right),
        .game_running (game_running),
        .game_over    (game_over),
        .winner       (winner),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Reference frame tick: vsync sampled 1 then 0, visible the following cycle.
    logic tb_vs_cur  = 1'b1;
    logic tb_vs_prev = 1'b1;
    always @(posedge clk) begin
        tb_vs_cur  <= vga_v_sync;
        tb_vs_prev <= tb_vs_cur;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ball_reset === 1'b1) br_cnt++;
        if (engine_step === 1'b1) begin
            step_cnt++;
            chk("step_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                int e;
                e = exp_q.pop_front();
                chk("step_state", 32'(state), 32'(e));
            end
`ifdef MATCH_CTRL_FRAME_STEP_EN
            if (!step_mode) chk("step_coincident", 32'(tb_vs_prev & ~tb_vs_cur), 1);
`else
            chk("step_coincident", 32'(tb_vs_prev & ~tb_vs_cur), 1);
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input bit in_play);
        if (in_play) exp_q.push_back(2);
        vga_v_sync = 1'b0;
        cyc(2);
        vga_v_sync = 1'b1;
        cyc(2);
    endtask

    task automatic frames(input int n, input bit in_play);
        for (int i = 0; i < n; i++) frame(in_play);
    endtask

    task automatic pt(input bit l, input bit r);
        point_left  = l;
        point_right = r;
        cyc(1);
        point_left  = 1'b0;
        point_right = 1'b0;
        cyc(1);
    endtask

    initial begin
        int s0;
        int b0;
        reset       = 1'b1;
        vga_v_sync  = 1'b1;
        start_game  = 1'b0;
        point_left  = 1'b0;
        point_right = 1'b0;
`ifdef MATCH_CTRL_FRAME_STEP_EN
        step_mode   = 1'b0;
        step_btn    = 1'b0;
`endif
        cyc(3);
        chk("rst_state", 32'(state), 0);
        chk("rst_score_l", 32'(score_left), 0);
        chk("rst_score_r", 32'(score_right), 0);
        chk("rst_serve_dir", 32'(serve_dir), 0);
        chk("rst_winner", 32'(winner), 0);
        chk("rst_ball_reset", 32'(ball_reset), 0);
        chk("rst_running", 32'(game_running), 0);

        // Start held high across reset release must not start a match.
        start_game = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(10);
        chk("held_start_idle", 32'(state), 0);

        start_game = 1'b0;
        cyc(3);
        b0 = br_cnt;
        start_game = 1'b1;
        cyc(3);
        chk("start_serve", 32'(state), 1);
        chk("start_ball_reset", 32'(br_cnt - b0), 1);
        chk("start_scores", 32'({score_left, score_right}), 0);
        chk("start_running", 32'(game_running), 1);

        frames(59, 0);
        chk("serve_59", 32'(state), 1);
        frame(0);
        chk("serve_60_play", 32'(state), 2);

        s0 = step_cnt;
        frames(5, 1);
        chk("play_5_steps", 32'(step_cnt - s0), 5);

        pt(1, 0);
        chk("pl_score_l", 32'(score_left), 1);
        chk("pl_serve_dir", 32'(serve_dir), 1);
        chk("pl_point", 32'(state), 3);
        pt(0, 1);
        chk("ignored_in_point", 32'(score_right), 0);
        b0 = br_cnt;
        frames(29, 0);
        chk("point_29", 32'(state), 3);
        frame(0);
        chk("point_30_serve", 32'(state), 1);
        chk("point_ball_reset", 32'(br_cnt - b0), 1);

        frames(60, 0);
        pt(1, 1);
        chk("draw_scores", 32'({score_left, score_right}), 32'h10);
        chk("draw_serve_dir", 32'(serve_dir), 0);
        chk("draw_point", 32'(state), 3);
        frames(30, 0);

        for (int i = 1; i <= 7; i++) begin
            frames(60, 0);
            pt(0, 1);
            chk("win_score_r", 32'(score_right), 32'(i));
            b0 = br_cnt;
            frames(30, 0);
            chk("win_after_point", 32'(state), (i < 7) ? 1 : 4);
            chk("win_ball_reset", 32'(br_cnt - b0), (i < 7) ? 1 : 0);
        end
        chk("over_flag", 32'(game_over), 1);
        chk("over_winner", 32'(winner), 1);
        chk("over_running", 32'(game_running), 0);
        chk("over_score_l", 32'(score_left), 1);
        pt(1, 0);
        chk("ignored_in_over", 32'(score_left), 1);

        start_game = 1'b0;
        cyc(3);
        chk("over_no_abort", 32'(state), 4);
        b0 = br_cnt;
        start_game = 1'b1;
        cyc(3);
        chk("restart_serve", 32'(state), 1);
        chk("restart_scores", 32'({score_left, score_right}), 0);
        chk("restart_ball_reset", 32'(br_cnt - b0), 1);

        frames(60, 0);
        pt(1, 0);
        start_game = 1'b0;
        cyc(1);
        chk("abort_idle", 32'(state), 0);
        chk("abort_score_held", 32'(score_left), 1);

        cyc(2);
        start_game = 1'b1;
        cyc(3);
        frames(60, 0);
        pt(0, 1);
        reset = 1'b1;
        cyc(1);
        chk("midreset_state", 32'(state), 0);
        chk("midreset_score", 32'(score_right), 0);
        reset = 1'b0;

`ifdef MATCH_CTRL_FRAME_STEP_EN
        start_game = 1'b0;
        cyc(3);
        start_game = 1'b1;
        cyc(3);
        frames(60, 0);
        chk("step_play", 32'(state), 2);
        step_mode = 1'b1;
        s0 = step_cnt;
        frames(3, 0);
        chk("step_vsync_ignored", 32'(step_cnt - s0), 0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(2);
            step_btn = 1'b1;
            cyc(3);
            step_btn = 1'b0;
            cyc(3);
        end
        chk("step_btn_steps", 32'(step_cnt - s0), 3);
`endif

        cyc(5);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
